// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: FSM encoding, reset PC and instruction field constants.
// This package is also used by the control decoder.
package instr_fetch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2} state_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W = 6;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pc_next.sv
// pc_next: sequential, beq-taken and jr next-PC selection, all mod 2^32.
module pc_next (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);
    logic [31:0] branch_pc;
    always_comb begin
        pc_plus4 = pc + 32'd4;
        branch_pc = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
        next_pc = jr_en ? (jr_target & 32'hFFFF_FFFC) : branch_taken ? branch_pc : pc_plus4;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register and IDLE/REQ/VALID fetch FSM feeding the decoder
// through a valid/ready handshake.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                branch_taken,
    input  logic [15:0]         branch_imm,
    input  logic                jr_en,
    input  logic [31:0]         jr_target
);
    state_t state, state_n;
    logic [31:0] next_pc;
    logic handshake;

    pc_next u_pc_next (
        .pc          (pc),
        .branch_taken(branch_taken),
        .branch_imm  (branch_imm),
        .jr_en       (jr_en),
        .jr_target   (jr_target),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );

    always_comb begin
        imem_req = (state == REQ);
        instr_valid = (state == VALID);
        handshake = instr_valid & instr_ready;
        imem_addr = pc;
        opcode = instr[OPCODE_MSB:OPCODE_LSB];
        state_n = (state == IDLE)  ? REQ :
                  (state == REQ)   ? (imem_ack ? VALID : REQ) :
                  (state == VALID) ? (instr_ready ? REQ : VALID) : IDLE;
    end

    // Outputs decode straight from state so reset withdraws req/valid at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            state <= state_n;
            if (imem_req && imem_ack) instr <= imem_rdata;
            if (handshake) pc <= next_pc;
        end
    end
endmodule
